// File: rtl/ov5640_ae_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_ae_pkg
// Description : Shared constants, FSM encoding and register helpers for the
//               OV5640 auto-exposure controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ov5640_ae_pkg;

    localparam int EXP_W = 20;

    localparam logic [15:0] REG_EXP_H = 16'h3500;
    localparam logic [15:0] REG_EXP_M = 16'h3501;
    localparam logic [15:0] REG_EXP_L = 16'h3502;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CALC     = 3'd1,
        ST_WR0      = 3'd2,
        ST_WR1      = 3'd3,
        ST_WR2      = 3'd4,
        ST_WAIT_GAP = 3'd5
    } ae_state_t;

    function automatic logic [15:0] wr_addr(input ae_state_t st);
        case (st)
            ST_WR0:  wr_addr = REG_EXP_H;
            ST_WR1:  wr_addr = REG_EXP_M;
            default: wr_addr = REG_EXP_L;
        endcase
    endfunction

    function automatic logic [7:0] wr_data(input ae_state_t st, input logic [EXP_W-1:0] e);
        case (st)
            ST_WR0:  wr_data = {4'h0, e[EXP_W-1:16]};
            ST_WR1:  wr_data = e[15:8];
            default: wr_data = e[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov5640_ae_ctrl_stat.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_ae_stat
// Description : Windowed luminance accumulator producing a per-frame mean and
//               a one-cycle frame_done pulse at the vsync falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module ov5640_ae_stat
    import ov5640_ae_pkg::*;
#(
    parameter logic [10:0] WIN_X0 = 11'd256,
    parameter logic [10:0] WIN_Y0 = 11'd128,
    parameter int          LOG_W  = 8,
    parameter int          LOG_H  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       de,
    input  logic [7:0] img_y,
    output logic [7:0] frame_mean,
    output logic       frame_done
);

    localparam int          ACC_W   = 8 + LOG_W + LOG_H;
    localparam logic [11:0] C_X_END = 12'(WIN_X0) + 12'(2 ** LOG_W);
    localparam logic [11:0] C_Y_END = 12'(WIN_Y0) + 12'(2 ** LOG_H);

    logic [10:0]      r_col_cnt;
    logic [10:0]      r_row_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_vs_d;
    logic             r_de_d;
    logic [7:0]       r_mean;
    logic             r_done;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_in_win;

    assign w_vs_rise = vsync & ~r_vs_d;
    assign w_vs_fall = ~vsync & r_vs_d;
    assign w_in_win  = (r_col_cnt >= WIN_X0) && ({1'b0, r_col_cnt} < C_X_END) &&
                       (r_row_cnt >= WIN_Y0) && ({1'b0, r_row_cnt} < C_Y_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_acc     <= '0;
            r_vs_d    <= 1'b0;
            r_de_d    <= 1'b0;
            r_mean    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_vs_d <= vsync;
            r_de_d <= de;
            r_done <= w_vs_fall;

            r_col_cnt <= de ? r_col_cnt + 11'd1 : 11'd0;

            if (!vsync)
                r_row_cnt <= '0;
            else if (!de && r_de_d)
                r_row_cnt <= r_row_cnt + 11'd1;

            if (w_vs_rise)
                r_acc <= '0;
            else if (de && w_in_win)
                r_acc <= r_acc + ACC_W'(img_y);

            // Always divide by the full window size, even on a truncated frame
            if (w_vs_fall)
                r_mean <= r_acc[ACC_W-1:LOG_W+LOG_H];
        end
    end

    assign frame_mean = r_mean;
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: rtl/ov5640_ae_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_ae_ctrl
// Description : Closed-loop auto-exposure: compares frame mean with target and
//               sequences the three OV5640 exposure-register writes via SCCB.
// Revision    : 1.0 - initial release
// ============================================================================
module ov5640_ae_ctrl
    import ov5640_ae_pkg::*;
#(
    parameter logic [10:0]      WIN_X0   = 11'd256,
    parameter logic [10:0]      WIN_Y0   = 11'd128,
    parameter int               LOG_W    = 8,
    parameter int               LOG_H    = 8,
    parameter logic [7:0]       HYST     = 8'd8,
    parameter logic [EXP_W-1:0] STEP     = 20'd64,
    parameter logic [EXP_W-1:0] EXP_MIN  = 20'd16,
    parameter logic [EXP_W-1:0] EXP_MAX  = 20'hFFFF0,
    parameter logic [EXP_W-1:0] EXP_INIT = 20'h04000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ae_en,
    input  logic [7:0]       target_y,
    input  logic             pre_frame_vsync,
    input  logic             pre_frame_de,
    input  logic [7:0]       img_y,
    output logic             i2c_req,
    output logic [15:0]      i2c_addr,
    output logic [7:0]       i2c_data,
    input  logic             i2c_ack,
    output logic [EXP_W-1:0] exposure,
    output logic [7:0]       frame_mean,
    output logic             busy
);

    logic w_frame_done;

    ov5640_ae_stat #(
        .WIN_X0 (WIN_X0),
        .WIN_Y0 (WIN_Y0),
        .LOG_W  (LOG_W),
        .LOG_H  (LOG_H)
    ) u_stat (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (pre_frame_vsync),
        .de         (pre_frame_de),
        .img_y      (img_y),
        .frame_mean (frame_mean),
        .frame_done (w_frame_done)
    );

    ae_state_t        r_state;
    ae_state_t        r_next;
    logic [EXP_W-1:0] r_exposure;
    logic             r_req;
    logic [15:0]      r_addr;
    logic [7:0]       r_data;
    logic             r_busy;

    logic [8:0]       w_mean9;
    logic [8:0]       w_tgt9;
    logic [8:0]       w_hyst9;
    logic             w_dark;
    logic             w_bright;
    logic [EXP_W:0]   w_inc;
    logic [EXP_W-1:0] w_up;
    logic [EXP_W-1:0] w_dn;
    logic [EXP_W-1:0] w_exp_new;

    assign w_mean9  = {1'b0, frame_mean};
    assign w_tgt9   = {1'b0, target_y};
    assign w_hyst9  = {1'b0, HYST};
    assign w_dark   = (w_mean9 + w_hyst9) < w_tgt9;
    assign w_bright = w_mean9 > (w_tgt9 + w_hyst9);

    // 21-bit arithmetic so neither the increment nor the floor test can wrap
    assign w_inc = {1'b0, r_exposure} + {1'b0, STEP};
    assign w_up  = (w_inc > {1'b0, EXP_MAX}) ? EXP_MAX : w_inc[EXP_W-1:0];
    assign w_dn  = ({1'b0, r_exposure} < ({1'b0, EXP_MIN} + {1'b0, STEP})) ?
                   EXP_MIN : (r_exposure - STEP);
    assign w_exp_new = w_dark ? w_up : (w_bright ? w_dn : r_exposure);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_next     <= ST_IDLE;
            r_exposure <= EXP_INIT;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_done && ae_en) begin
                        r_state <= ST_CALC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (w_exp_new == r_exposure) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_exposure <= w_exp_new;
                        r_state    <= ST_WR0;
                        r_req      <= 1'b1;
                        r_addr     <= wr_addr(ST_WR0);
                        r_data     <= wr_data(ST_WR0, w_exp_new);
                    end
                end
                ST_WR0, ST_WR1, ST_WR2: begin
                    // ae_en is deliberately not consulted: a started group always finishes
                    if (i2c_ack && r_req) begin
                        r_req   <= 1'b0;
                        r_state <= ST_WAIT_GAP;
                        r_next  <= (r_state == ST_WR0) ? ST_WR1 :
                                   (r_state == ST_WR1) ? ST_WR2 : ST_IDLE;
                    end
                end
                ST_WAIT_GAP: begin
                    if (r_next == ST_IDLE) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= r_next;
                        r_req   <= 1'b1;
                        r_addr  <= wr_addr(r_next);
                        r_data  <= wr_data(r_next, r_exposure);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign i2c_req  = r_req;
    assign i2c_addr = r_addr;
    assign i2c_data = r_data;
    assign exposure = r_exposure;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ov5640_ae_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov5640_ae_ctrl
// Description : Directed self-checking bench; three controller instances share
//               frame timing, two of them start near the exposure clamps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov5640_ae_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ae_en = 1'b0;
    logic       vsync = 1'b0;
    logic       de = 1'b0;
    logic [7:0] target_m = 8'd128;
    logic [7:0] y_m = 8'd0, y_l = 8'd0, y_h = 8'd0;
    logic       ack_m, ack_l, ack_h;

    logic        req_m, req_l, req_h, busy_m, busy_l, busy_h;
    logic [15:0] addr_m, addr_l, addr_h;
    logic [7:0]  data_m, data_l, data_h, mean_m, mean_l, mean_h;
    logic [19:0] exp_m, exp_l, exp_h;

    int n_tests = 0;
    int n_fail = 0;

    logic [7:0]  in_m = 8'd0, out_m = 8'd0, val_l = 8'd0, val_h = 8'd0;
    bit          slow_wr1 = 1'b0;
    logic [23:0] q_m[$], q_l[$], q_h[$];

    ov5640_ae_ctrl #(.WIN_X0(11'd2), .WIN_Y0(11'd1), .LOG_W(2), .LOG_H(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .ae_en(ae_en), .target_y(target_m),
        .pre_frame_vsync(vsync), .pre_frame_de(de), .img_y(y_m),
        .i2c_req(req_m), .i2c_addr(addr_m), .i2c_data(data_m), .i2c_ack(ack_m),
        .exposure(exp_m), .frame_mean(mean_m), .busy(busy_m));

    ov5640_ae_ctrl #(.WIN_X0(11'd2), .WIN_Y0(11'd1), .LOG_W(2), .LOG_H(2),
                     .EXP_INIT(20'd26)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .ae_en(ae_en), .target_y(8'd128),
        .pre_frame_vsync(vsync), .pre_frame_de(de), .img_y(y_l),
        .i2c_req(req_l), .i2c_addr(addr_l), .i2c_data(data_l), .i2c_ack(ack_l),
        .exposure(exp_l), .frame_mean(mean_l), .busy(busy_l));

    ov5640_ae_ctrl #(.WIN_X0(11'd2), .WIN_Y0(11'd1), .LOG_W(2), .LOG_H(2),
                     .EXP_INIT(20'hFFFC0)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .ae_en(ae_en), .target_y(8'd128),
        .pre_frame_vsync(vsync), .pre_frame_de(de), .img_y(y_h),
        .i2c_req(req_h), .i2c_addr(addr_h), .i2c_data(data_h), .i2c_ack(ack_h),
        .exposure(exp_h), .frame_mean(mean_h), .busy(busy_h));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // SCCB slave model: acks each request, optionally stalling the middle write
    initial begin
        ack_m = 1'b0;
        forever begin
            @(negedge clk);
            if (req_m === 1'b1) begin
                if (slow_wr1 && addr_m == 16'h3501)
                    repeat (200) @(negedge clk);
                if (req_m === 1'b1) begin
                    q_m.push_back({addr_m, data_m});
                    ack_m = 1'b1;
                    @(negedge clk);
                    ack_m = 1'b0;
                    check("req_gap", 32'(req_m), 32'd0);
                end
            end
        end
    end

    initial begin
        ack_l = 1'b0;
        forever begin
            @(negedge clk);
            if (req_l === 1'b1) begin
                q_l.push_back({addr_l, data_l});
                ack_l = 1'b1;
                @(negedge clk);
                ack_l = 1'b0;
            end
        end
    end

    initial begin
        ack_h = 1'b0;
        forever begin
            @(negedge clk);
            if (req_h === 1'b1) begin
                q_h.push_back({addr_h, data_h});
                ack_h = 1'b1;
                @(negedge clk);
                ack_h = 1'b0;
            end
        end
    end

    // 8x6 frame, stats window is columns 2..5, rows 1..4
    task automatic run_frame();
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                de  = 1'b1;
                y_m = (c >= 2 && c < 6 && r >= 1 && r < 5) ? in_m : out_m;
                y_l = val_l;
                y_h = val_h;
                @(negedge clk);
            end
            de  = 1'b0;
            y_m = 8'd0;
            y_l = 8'd0;
            y_h = 8'd0;
            repeat (4) @(negedge clk);
        end
        vsync = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while ((busy_m || busy_l || busy_h) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy_m || busy_l || busy_h), 32'd0);
    endtask

    task automatic check_seq(input string tag, input logic [23:0] q[$], input int base,
                             input logic [19:0] e);
        logic [23:0] exp_w [3];
        exp_w[0] = {16'h3500, 4'h0, e[19:16]};
        exp_w[1] = {16'h3501, e[15:8]};
        exp_w[2] = {16'h3502, e[7:0]};
        check({tag, "_count"}, 32'(q.size() - base), 32'd3);
        if (q.size() >= base + 3)
            for (int i = 0; i < 3; i++)
                check($sformatf("%s_wr%0d", tag, i), 32'(q[base+i]), 32'(exp_w[i]));
    endtask

    initial begin
        int lat;
        int base;
        bit found;

        repeat (3) @(negedge clk);
        check("rst_exposure", 32'(exp_m), 32'h04000);
        check("rst_req", 32'(req_m), 32'd0);
        check("rst_addr", 32'(addr_m), 32'd0);
        check("rst_data", 32'(data_m), 32'd0);
        check("rst_mean", 32'(mean_m), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_exp_lo", 32'(exp_l), 32'd26);
        check("rst_exp_hi", 32'(exp_h), 32'hFFFC0);
        rst_n = 1'b1;

        // Dark frame on main and hi, bright frame on lo
        ae_en = 1'b1; in_m = 8'd40; out_m = 8'd40; val_l = 8'd250; val_h = 8'd40;
        run_frame();
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (req_m && lat == 0) lat = i;
        end
        check("req_latency", 32'(lat), 32'd3);
        wait_idle("t1_idle", 100);
        check("t1_mean", 32'(mean_m), 32'd40);
        check("t1_exposure", 32'(exp_m), 32'h04040);
        check_seq("t1_seq", q_m, 0, 20'h04040);
        check("t1_mean_lo", 32'(mean_l), 32'd250);
        check("t1_exp_lo", 32'(exp_l), 32'd16);
        check_seq("t1_seq_lo", q_l, 0, 20'd16);
        check("t1_mean_hi", 32'(mean_h), 32'd40);
        check("t1_exp_hi", 32'(exp_h), 32'hFFFF0);
        check_seq("t1_seq_hi", q_h, 0, 20'hFFFF0);

        // Inside the dead band; lo/hi sit at their clamps
        in_m = 8'd125; out_m = 8'd125;
        run_frame();
        @(negedge clk);
        @(negedge clk);
        check("t2_busy_calc", 32'(busy_m), 32'd1);
        @(negedge clk);
        check("t2_busy_back", 32'(busy_m), 32'd0);
        wait_idle("t2_idle", 50);
        check("t2_mean", 32'(mean_m), 32'd125);
        check("t2_exposure", 32'(exp_m), 32'h04040);
        check("t2_writes", 32'(q_m.size()), 32'd3);
        check("t2_exp_lo", 32'(exp_l), 32'd16);
        check("t2_writes_lo", 32'(q_l.size()), 32'd3);
        check("t2_exp_hi", 32'(exp_h), 32'hFFFF0);
        check("t2_writes_hi", 32'(q_h.size()), 32'd3);

        // Only the window contributes to the mean
        in_m = 8'd64; out_m = 8'd255; target_m = 8'd64; val_l = 8'd128; val_h = 8'd128;
        run_frame();
        repeat (4) @(negedge clk);
        wait_idle("t3_idle", 50);
        check("t3_mean", 32'(mean_m), 32'd64);
        check("t3_writes", 32'(q_m.size()), 32'd3);
        check("t3_exposure", 32'(exp_m), 32'h04040);

        // Disabled: statistics only
        ae_en = 1'b0; in_m = 8'd40; out_m = 8'd40; target_m = 8'd128;
        run_frame();
        repeat (2) @(negedge clk);
        check("t4_busy", 32'(busy_m), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_mean", 32'(mean_m), 32'd40);
        check("t4_writes", 32'(q_m.size()), 32'd3);
        check("t4_exposure", 32'(exp_m), 32'h04040);

        // Stalled WR1 while another frame ends
        ae_en = 1'b1; slow_wr1 = 1'b1;
        base = q_m.size();
        run_frame();
        in_m = 8'd100; out_m = 8'd100;
        run_frame();
        repeat (3) @(negedge clk);
        check("t5_mean", 32'(mean_m), 32'd100);
        check("t5_busy", 32'(busy_m), 32'd1);
        check("t5_req", 32'(req_m), 32'd1);
        check("t5_addr", 32'(addr_m), 32'h3501);
        check("t5_exposure", 32'(exp_m), 32'h04080);
        wait_idle("t5_idle", 400);
        check_seq("t5_seq", q_m, base, 20'h04080);
        repeat (10) @(negedge clk);
        check("t5_no_extra", 32'(q_m.size() - base), 32'd3);
        check("t5_exp_final", 32'(exp_m), 32'h04080);

        // Reset in the middle of WR1
        base = q_m.size();
        in_m = 8'd40; out_m = 8'd40;
        run_frame();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (req_m && addr_m == 16'h3501) found = 1'b1;
        end
        check("t6_wr1_seen", 32'(found), 32'd1);
        check("t6_exp_pre", 32'(exp_m), 32'h040C0);
        rst_n = 1'b0;
        #1;
        check("t6_req_async", 32'(req_m), 32'd0);
        check("t6_exp_rst", 32'(exp_m), 32'h04000);
        check("t6_busy_rst", 32'(busy_m), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (250) @(negedge clk);
        check("t6_busy_after", 32'(busy_m), 32'd0);
        check("t6_req_after", 32'(req_m), 32'd0);
        check("t6_no_rewrite", 32'(q_m.size() - base), 32'd1);
        check("t6_exp_after", 32'(exp_m), 32'h04000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
